// File: rtl/mem_responder_if.sv
// Request/acknowledge bus between the MDR/MAR side and the memory responder.
interface mem_responder_if;
  logic        read;
  logic        write;
  logic [8:0]  address;
  logic [31:0] datain;
  logic [31:0] dataout;
  logic        done;

  modport slave (
    input  read, write, address, datain,
    output dataout, done
  );

  modport master (
    output read, write, address, datain,
    input  dataout, done
  );
endinterface

// File: rtl/mem_responder.sv
// Word memory with WAIT_CYCLES wait states and a four-phase read/write/done handshake.
// done and dataout are valid WAIT_CYCLES+1 edges after capture; done holds until the request drops.
module mem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH       = 512
) (
  input logic            clock,
  input logic            clear,
  mem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [8:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        wr_q, wr_d;
  logic        done_q, done_d;
  logic [31:0] dout_q;
  logic        mem_we, mem_re;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 9'd0;
      data_q  <= 32'd0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      if (mem_re) dout_q <= mem[addr_q];
    end
  end

  // Storage is deliberately outside the reset domain so clear never alters contents.
  always_ff @(posedge clock) begin
    if (mem_we) mem[addr_q] <= data_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    done_d  = done_q;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    unique case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (bus.read || bus.write) begin
          addr_d  = bus.address;
          data_d  = bus.datain;
          wr_d    = bus.write;  // write wins when both are requested
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ACCESS;
      end
      ACCESS: begin
        mem_we  = !clear && wr_q;
        mem_re  = !clear && !wr_q;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (!bus.read && !bus.write) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.done    = done_q;
  assign bus.dataout = dout_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboarded bench: one responder with two wait states, one with none.
module tb_mem_responder;

  logic clock = 1'b0;
  logic clear = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mem_responder_if bus2();
  mem_responder_if bus0();

  mem_responder #(.WAIT_CYCLES(2), .DEPTH(512)) dut2 (.clock(clock), .clear(clear), .bus(bus2));
  mem_responder #(.WAIT_CYCLES(0), .DEPTH(512)) dut0 (.clock(clock), .clear(clear), .bus(bus0));

  typedef struct {
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  exp_t q2[$];
  exp_t q0[$];
  logic prev2 = 1'b0;
  logic prev0 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: every rising done must match the oldest expected response.
  always @(negedge clock) begin
    if (bus2.done === 1'b1 && prev2 !== 1'b1) begin
      if (q2.size() == 0) chk("w2_unexpected_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q2.pop_front();
        chk("w2_dataout", bus2.dataout, e.dat);
        chk("w2_latency", cyc, e.cyc);
      end
    end
    prev2 = bus2.done;
  end

  always @(negedge clock) begin
    if (bus0.done === 1'b1 && prev0 !== 1'b1) begin
      if (q0.size() == 0) chk("w0_unexpected_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q0.pop_front();
        chk("w0_dataout", bus0.dataout, e.dat);
        chk("w0_latency", cyc, e.cyc);
      end
    end
    prev0 = bus0.done;
  end

  function automatic logic done_of(input bit sel);
    return sel ? bus0.done : bus2.done;
  endfunction

  task automatic drive(input bit sel, input logic rd, input logic wr,
                       input logic [8:0] a, input logic [31:0] d);
    if (sel) begin
      bus0.read = rd; bus0.write = wr; bus0.address = a; bus0.datain = d;
    end else begin
      bus2.read = rd; bus2.write = wr; bus2.address = a; bus2.datain = d;
    end
  endtask

  // sel=1 targets the zero-wait responder. hold: extra cycles the request stays high after done.
  // early: drop the request right after capture. chg: corrupt address/data right after capture.
  task automatic access(input bit sel, input logic rd, input logic wr,
                        input logic [8:0] a, input logic [31:0] d,
                        input logic [31:0] exp_dout, input int hold,
                        input bit early, input bit chg);
    exp_t e;
    bit   got;
    int   lat;
    lat = sel ? 0 : 2;
    @(posedge clock); #1;
    drive(sel, rd, wr, a, d);
    e.dat = exp_dout;
    e.cyc = cyc + lat + 2;
    if (sel) q0.push_back(e); else q2.push_back(e);
    if (early || chg) begin
      @(posedge clock); #1;
      if (chg)   drive(sel, rd, wr, ~a, ~d);
      if (early) drive(sel, 1'b0, 1'b0, a, d);
    end
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (done_of(sel) === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clock);
        chk("done_hold", {31'd0, done_of(sel)}, 32'd1);
      end
      @(posedge clock); #1;
      drive(sel, 1'b0, 1'b0, a, d);
      @(negedge clock);
      chk("done_before_fall", {31'd0, done_of(sel)}, 32'd1);
    end
    @(negedge clock);
    chk("done_fall", {31'd0, done_of(sel)}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 9'd0, 32'd0);
    repeat (3) @(posedge clock);
    #1 clear = 1'b0;
    @(negedge clock);
    chk("rst_done2", {31'd0, bus2.done}, 32'd0);
    chk("rst_dout2", bus2.dataout, 32'h0);
    chk("rst_done0", {31'd0, bus0.done}, 32'd0);
    chk("rst_dout0", bus0.dataout, 32'h0);

    // Two-wait-state responder
    access(1'b0, 1'b0, 1'b1, 9'h010, 32'hAAAAAAAA, 32'h00000000, 0, 1'b0, 1'b0);
    access(1'b0, 1'b1, 1'b0, 9'h010, 32'h00000000, 32'hAAAAAAAA, 0, 1'b0, 1'b0);
    access(1'b0, 1'b1, 1'b0, 9'h010, 32'h00000000, 32'hAAAAAAAA, 5, 1'b0, 1'b0);
    access(1'b0, 1'b1, 1'b1, 9'h020, 32'hFFFFFFFF, 32'hAAAAAAAA, 0, 1'b0, 1'b0);
    access(1'b0, 1'b1, 1'b0, 9'h020, 32'h00000000, 32'hFFFFFFFF, 0, 1'b0, 1'b0);
    access(1'b0, 1'b0, 1'b1, 9'h030, 32'h0BADF00D, 32'hFFFFFFFF, 0, 1'b0, 1'b0);

    // Abort a write to 0x030 while it is waiting
    @(posedge clock); #1;
    drive(1'b0, 1'b0, 1'b1, 9'h030, 32'h12345678);
    @(posedge clock); #1;
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 9'h030, 32'h0);
    @(negedge clock);
    chk("abort_done", {31'd0, bus2.done}, 32'd0);
    chk("abort_dout", bus2.dataout, 32'h0);
    repeat (4) @(negedge clock);
    chk("abort_no_done", {31'd0, bus2.done}, 32'd0);
    access(1'b0, 1'b1, 1'b0, 9'h030, 32'h00000000, 32'h0BADF00D, 0, 1'b0, 1'b0);

    // Inputs changed after capture must not affect the access
    access(1'b0, 1'b0, 1'b1, 9'h1BF, 32'h11111111, 32'h0BADF00D, 0, 1'b0, 1'b0);
    access(1'b0, 1'b0, 1'b1, 9'h040, 32'h55AA55AA, 32'h0BADF00D, 0, 1'b0, 1'b1);
    access(1'b0, 1'b1, 1'b0, 9'h040, 32'h00000000, 32'h55AA55AA, 0, 1'b1, 1'b0);
    access(1'b0, 1'b1, 1'b0, 9'h1BF, 32'h00000000, 32'h11111111, 0, 1'b0, 1'b0);
    access(1'b0, 1'b1, 1'b0, 9'h010, 32'h00000000, 32'hAAAAAAAA, 0, 1'b0, 1'b1);

    // Zero-wait responder, last word of the array
    access(1'b1, 1'b0, 1'b1, 9'h1FF, 32'h13579BDF, 32'h00000000, 0, 1'b0, 1'b0);
    access(1'b1, 1'b1, 1'b0, 9'h1FF, 32'h00000000, 32'h13579BDF, 0, 1'b0, 1'b0);
    access(1'b1, 1'b0, 1'b1, 9'h000, 32'h2468ACE0, 32'h13579BDF, 0, 1'b0, 1'b0);
    access(1'b1, 1'b1, 1'b0, 9'h1FF, 32'h00000000, 32'h13579BDF, 0, 1'b0, 1'b0);
    access(1'b1, 1'b1, 1'b0, 9'h000, 32'h00000000, 32'h2468ACE0, 2, 1'b0, 1'b0);

    repeat (3) @(negedge clock);
    chk("queues_drained", 32'(q0.size() + q2.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
